pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RV32 pipeline. Drives PC enable, plus stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Sources of control:
- load-use hazards
- EX-stage branch/jump redirects
- multi-cycle data-memory waits
- a halt/drain/resume request from the debug/test harness

Also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, redirect, memory wait
// and debug halt/drain/resume, with saturating perf counters and a sticky timeout flag.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT  = 16,
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             halt_req,
   input  logic             resume_req,
   output logic             pc_en,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             mem_wb_flush,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t              state, state_nxt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [DRAIN_W-1:0]  drain_cnt;
   logic                mem_wait;
   logic                load_use;
   logic                redirect_applied;

   assign mem_wait = mem_req & ~mem_ready;
   assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

   always_comb begin
      state_nxt        = state;
      pc_en            = 1'b0;
      if_id_stall      = 1'b0;
      if_id_flush      = 1'b0;
      id_ex_stall      = 1'b0;
      id_ex_flush      = 1'b0;
      ex_mem_stall     = 1'b0;
      mem_wb_flush     = 1'b0;
      halted           = 1'b0;
      redirect_applied = 1'b0;
      if (rst) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (mem_wait) begin
                  // frozen EX keeps redirect/load-use alive until the access completes
                  if_id_stall  = 1'b1;
                  id_ex_stall  = 1'b1;
                  ex_mem_stall = 1'b1;
                  mem_wb_flush = 1'b1;
               end else if (ex_redirect) begin
                  pc_en            = 1'b1;
                  if_id_flush      = 1'b1;
                  id_ex_flush      = 1'b1;
                  redirect_applied = 1'b1;
               end else if (load_use) begin
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end else begin
                  pc_en = 1'b1;
               end
               if (halt_req && !mem_wait && !ex_redirect)
                  state_nxt = DRAIN;
            end
            DRAIN: begin
               if (mem_wait) begin
                  if_id_stall  = 1'b1;
                  id_ex_stall  = 1'b1;
                  ex_mem_stall = 1'b1;
                  mem_wb_flush = 1'b1;
               end else begin
                  if_id_flush = 1'b1;
                  if (ex_redirect) begin
                     pc_en            = 1'b1;
                     id_ex_flush      = 1'b1;
                     redirect_applied = 1'b1;
                  end else if (load_use) begin
                     id_ex_flush = 1'b1;
                  end
                  if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1))
                     state_nxt = HALTED;
               end
            end
            HALTED: begin
               halted      = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               if (resume_req)
                  state_nxt = RUN;
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         drain_cnt   <= '0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         state <= state_nxt;

         if (!mem_wait)
            wait_cnt <= '0;
         else if (wait_cnt != WAIT_W'(MEM_TIMEOUT))
            wait_cnt <= wait_cnt + WAIT_W'(1);

         if (mem_wait && wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))
            mem_timeout <= 1'b1;

         if (state == RUN && state_nxt == DRAIN)
            drain_cnt <= '0;
         else if (state == DRAIN && !mem_wait)
            drain_cnt <= drain_cnt + DRAIN_W'(1);

         if (state == RUN && !pc_en && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);

         if (redirect_applied && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for single-cycle priority plus
// hand sequences for waits, timeout, drain/halt/resume and mid-operation reset.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
   logic        mem_req, mem_ready, halt_req, resume_req;
   logic        pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic        ex_mem_stall, mem_wb_flush, halted, mem_timeout;
   logic [31:0] stall_cnt, flush_cnt;
   logic [6:0]  ctrl;

   int n_cmp = 0;
   int n_bad = 0;

   // {pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
   localparam logic [6:0] C_RUN    = 7'b1000000;
   localparam logic [6:0] C_LU     = 7'b0100100;
   localparam logic [6:0] C_REDIR  = 7'b1010100;
   localparam logic [6:0] C_FREEZE = 7'b0101011;
   localparam logic [6:0] C_RST    = 7'b0010100;
   localparam logic [6:0] C_DRAIN  = 7'b0010000;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, redir, mreq, mrdy;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[11];

   pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .DRAIN_CYCLES(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_req(mem_req),
      .mem_ready(mem_ready), .halt_req(halt_req), .resume_req(resume_req),
      .pc_en(pc_en), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
      .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
      .halted(halted), .mem_timeout(mem_timeout),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   assign ctrl = {pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_ctrl(input string name, input logic [6:0] exp);
      #1;
      chk(name, {25'd0, ctrl}, {25'd0, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_lu();
      id_rs1 = 5'd5; ex_rd = 5'd5; id_uses_rs1 = 1'b1; ex_mem_read = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN};
      vecs[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
      vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN};
      vecs[3]  = '{5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
      vecs[4]  = '{5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN};
      vecs[5]  = '{5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN};
      vecs[6]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_REDIR};
      vecs[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_FREEZE};
      vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN};
      vecs[9]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_FREEZE};
      vecs[10] = '{5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN};

      // reset state, both during and after rst
      idle();
      rst = 1'b1;
      chk_ctrl("ctrl_in_rst", C_RST);
      chk("halted_in_rst", {31'd0, halted}, 32'd0);
      tick();
      rst = 1'b0;
      chk_ctrl("ctrl_after_rst", C_RUN);
      chk("stall_cnt_rst", stall_cnt, 32'd0);
      chk("flush_cnt_rst", flush_cnt, 32'd0);
      chk("timeout_rst", {31'd0, mem_timeout}, 32'd0);
      chk("halted_rst", {31'd0, halted}, 32'd0);

      // one load-use stall, then the bubble releases it
      set_lu();
      chk_ctrl("lu_stall", C_LU);
      tick();
      ex_mem_read = 1'b0;
      chk_ctrl("lu_release", C_RUN);
      chk("lu_stall_cnt", stall_cnt, 32'd1);
      tick();
      idle();

      for (int i = 0; i < 11; i++) begin
         id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
         id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2; ex_mem_read = vecs[i].mr;
         ex_redirect = vecs[i].redir; mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
         chk_ctrl($sformatf("vec%0d", i), vecs[i].exp);
         tick();
      end
      idle();
      #1;
      chk("table_stall_cnt", stall_cnt, 32'd5);
      chk("table_flush_cnt", flush_cnt, 32'd1);

      // three wait cycles with a held redirect, then the redirect lands
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk_ctrl($sformatf("wait_freeze%0d", i), C_FREEZE);
         tick();
      end
      mem_ready = 1'b1;
      chk_ctrl("wait_release_redir", C_REDIR);
      tick();
      idle();
      #1;
      chk("wait_flush_cnt", flush_cnt, 32'd1);
      chk("wait_stall_cnt", stall_cnt, 32'd3);
      chk("wait_no_timeout", {31'd0, mem_timeout}, 32'd0);

      // 20 wait cycles: flag sets on the 16th edge, pipeline stays frozen
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk($sformatf("timeout_after%0d", i), {31'd0, mem_timeout}, (i >= 16) ? 32'd1 : 32'd0);
      end
      chk_ctrl("timeout_frozen", C_FREEZE);
      mem_ready = 1'b1;
      tick();
      idle();
      #1;
      chk("timeout_sticky", {31'd0, mem_timeout}, 32'd1);

      // mid-wait reset with counters and timeout flag nonzero
      set_lu();
      tick();
      idle();
      ex_redirect = 1'b1;
      tick();
      idle();
      mem_req = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      #1;
      chk("pre_rst_stall_nz", {31'd0, stall_cnt != 32'd0}, 32'd1);
      rst = 1'b1;
      chk_ctrl("midwait_rst_ctrl", C_RST);
      tick();
      rst = 1'b0;
      mem_req = 1'b0;
      chk_ctrl("post_rst_run", C_RUN);
      chk("post_rst_stall", stall_cnt, 32'd0);
      chk("post_rst_flush", flush_cnt, 32'd0);
      chk("post_rst_timeout", {31'd0, mem_timeout}, 32'd0);

      // halt pulse: four drain cycles, then halted
      do_reset();
      halt_req = 1'b1;
      chk_ctrl("halt_req_cycle", C_RUN);
      tick();
      halt_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_ctrl($sformatf("drain%0d", i), C_DRAIN);
         chk($sformatf("drain_halted%0d", i), {31'd0, halted}, 32'd0);
         tick();
      end
      chk_ctrl("halted_ctrl", C_RST);
      chk("halted_set", {31'd0, halted}, 32'd1);
      halt_req = 1'b1;
      tick();
      chk("halted_hold", {31'd0, halted}, 32'd1);
      resume_req = 1'b1;
      tick();
      idle();
      chk_ctrl("resume_run", C_RUN);
      chk("resume_halted", {31'd0, halted}, 32'd0);

      // second drain: two waits and a redirect extend it to six cycles
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mem_req = (i == 1 || i == 2);
         ex_redirect = (i == 3);
         chk_ctrl($sformatf("drain2_%0d", i),
                  (i == 1 || i == 2) ? C_FREEZE : ((i == 3) ? C_REDIR : C_DRAIN));
         chk($sformatf("drain2_halted%0d", i), {31'd0, halted}, 32'd0);
         tick();
      end
      idle();
      #1;
      chk("drain2_halted", {31'd0, halted}, 32'd1);
      chk("drain_stall_cnt", stall_cnt, 32'd0);
      chk("drain_flush_cnt", flush_cnt, 32'd1);
      halt_req = 1'b1; resume_req = 1'b1;
      tick();
      idle();
      chk("resume_wins", {31'd0, halted}, 32'd0);
      chk_ctrl("resume_wins_ctrl", C_RUN);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
